rv32_uart_tx: RTL and testbench
===============================

// Module: rv32_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter; bus responder for the rv32 core's data bus
//  (address/write_mask/write_value from the core, read_value back to it).
//  Buffers bytes written by software in a FIFO and serialises them 8N1 on tx_out.
//  Reads are combinational and side-effect free; the bus has no read strobe.
// PARAMETERS
//  BASE_ADDR        32'h0001_0000  16-byte-aligned base of the register window
//  FIFO_DEPTH       16             TX FIFO entries; power of two, >= 2
//  DEFAULT_DIVISOR  16'd104        clk cycles per serial bit after reset
// PORTS
//  clk             in   1   clock, rising-edge
//  reset           in   1   asynchronous, active-high reset
//  address_in      in   32  byte address from core
//  write_mask_in   in   4   byte write enables; all-zero = no write
//  write_value_in  in   32  write data
//  read_value_out  out  32  read data, combinational from address_in
//  tx_out          out  1   serial line, idle high
// BEHAVIOUR
//  Select: sel = (address_in[31:4] == BASE_ADDR[31:4]); offset = address_in[3:2].
//  Registers: off0 DATA (W), off1 STATUS (R/W1C), off2 DIVISOR (R/W), off3 reserved.
//  - DATA write (sel, off0, write_mask_in[0]): push write_value_in[7:0]; DATA reads 0.
//  - STATUS read: [0] busy (state!=IDLE), [1] full, [2] empty, [3] overflow,
//    [15:8] FIFO count (zero-extended), other bits 0. Write with mask[0] and
//    value[3]=1 clears overflow; other bits read-only.
//  - DIVISOR: [15:0]; mask[0]/[1] write low/high byte; [31:16] read 0.
//  - Unselected address or off3: read_value_out = 0, writes ignored.
//  FIFO: push when full -> byte dropped, overflow set (sticky). Push and pop in
//   same cycle while full -> push accepted (count unchanged).
//  FSM states IDLE, START, DATA, STOP (+PARITY, see CONFIGURATION):
//   IDLE  -> START when FIFO non-empty; head popped into shift reg on that edge.
//   START -> DATA after one bit period, tx_out=0.
//   DATA  -> 8 bits LSB-first, one bit period each, then STOP.
//   STOP  -> tx_out=1 one bit period; then START (popping) if non-empty, else IDLE.
//  Bit period: counter loads max(DIVISOR,1)-1 at every bit start, counts down;
//   bit ends at 0. DIVISOR writes mid-frame take effect at next bit boundary.
//  Latency: DATA write on edge E into empty FIFO, idle FSM -> tx_out low after
//   edge E+1; frame = 10 bit periods; back-to-back frames have no idle gap.
//  tx_out is registered (no glitches).
//  Reset (any time, incl. mid-frame): tx_out=1 immediately, state=IDLE,
//   FIFO empty (count 0), overflow=0, DIVISOR=DEFAULT_DIVISOR, bit counter=0;
//   partial frame is abandoned. read_value_out follows registers combinationally.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state between DATA and STOP transmits even
//   parity (XOR of the 8 data bits) for one bit period; frame = 11 bit periods.
//   STATUS[4] reads 1 to indicate parity support.
//  Undefined: no PARITY state, 8N1 framing, STATUS[4] reads 0.
// TESTING
//  1 reset, read BASE+4 -> 32'h0000_0004 (empty); BASE+8 -> 104; tx_out=1.
//  2 DIVISOR=4, write 8'hA5 to DATA -> tx_out low after next edge, then
//    1,0,1,0,0,1,0,1 at 4 cycles/bit, stop 1; 40 cycles total; empty, busy=0 after.
//  3 DIVISOR=2, write 17 bytes back-to-back with FSM idle: first pops, then
//    16 fill FIFO; with FIFO_DEPTH=16 an 18th write sets overflow; write
//    BASE+4 value 8 clears it; frames emitted with no idle gap between.
//  4 assert reset mid-DATA bit 3 -> tx_out=1 same cycle, STATUS count 0,
//    DIVISOR back to 104; subsequent write transmits a clean frame.
//  5 write to BASE+12 and to BASE+16 -> no state change, reads return 0;
//    DIVISOR=0 -> 1-cycle bits.
//  6 with UART_TX_PARITY_EN, DIVISOR=1, send 8'h07 -> parity bit 1 before stop,
//    11-cycle frame; STATUS[4]=1.

Source files
------------

// File: rtl/rv32_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, responding on the rv32 data bus.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module rv32_uart_tx #(
  parameter logic [31:0] BASE_ADDR       = 32'h0001_0000,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  output logic        tx_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_SUPPORT = 1'b1;
`else
  localparam logic PARITY_SUPPORT = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic             sel;
  logic [1:0]       offset;
  logic             data_wr;
  logic             status_wr;
  logic             div_wr_lo;
  logic             div_wr_hi;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       count_byte;
  logic [7:0]       head_byte;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             overflow_set;

  logic             overflow;
  logic [15:0]      divisor;
  logic [15:0]      bit_load;

  state_t           state;
  logic [15:0]      bit_cnt;
  logic             bit_end;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_idx;
  logic             tx_reg;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  logic             unused_bits;

  // Bus decode
  assign sel       = (address_in[31:4] == BASE_ADDR[31:4]);
  assign offset    = address_in[3:2];
  assign data_wr   = sel && (offset == 2'd0) && write_mask_in[0];
  assign status_wr = sel && (offset == 2'd1) && write_mask_in[0];
  assign div_wr_lo = sel && (offset == 2'd2) && write_mask_in[0];
  assign div_wr_hi = sel && (offset == 2'd2) && write_mask_in[1];

  assign unused_bits = ^{address_in[1:0], write_mask_in[3:2], write_value_in[31:16]};

  // FIFO status and handshakes
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign count_byte = 8'(count);
  assign head_byte  = fifo_mem[rd_ptr];
  assign bit_end    = (bit_cnt == '0);

  assign pop = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push         = data_wr && (!full || pop);
  assign overflow_set = data_wr && full && !pop;

  assign bit_load = (divisor == '0) ? '0 : (divisor - 16'd1);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= write_value_in[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      divisor  <= DEFAULT_DIVISOR;
    end else begin
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (status_wr && write_value_in[3]) begin
        overflow <= 1'b0;
      end
      if (div_wr_lo) begin
        divisor[7:0] <= write_value_in[7:0];
      end
      if (div_wr_hi) begin
        divisor[15:8] <= write_value_in[15:8];
      end
    end
  end

  // Serialiser: tx_reg is set on the edge that enters each bit so the line never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx_reg    <= 1'b1;
      bit_cnt   <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state     <= START;
            tx_reg    <= 1'b0;
            bit_cnt   <= bit_load;
            shift_reg <= head_byte;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^head_byte;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx_reg  <= shift_reg[0];
            bit_idx <= '0;
            bit_cnt <= bit_load;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= bit_load;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
              tx_reg <= parity_bit;
`else
              state  <= STOP;
              tx_reg <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx_reg    <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            tx_reg  <= 1'b1;
            bit_cnt <= bit_load;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (!empty) begin
              state     <= START;
              tx_reg    <= 1'b0;
              bit_cnt   <= bit_load;
              shift_reg <= head_byte;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^head_byte;
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_reg <= 1'b1;
        end
      endcase
    end
  end

  assign tx_out = tx_reg;

  always_comb begin
    read_value_out = '0;
    if (sel) begin
      case (offset)
        2'd1: begin
          read_value_out[0]    = (state != IDLE);
          read_value_out[1]    = full;
          read_value_out[2]    = empty;
          read_value_out[3]    = overflow;
          read_value_out[4]    = PARITY_SUPPORT;
          read_value_out[15:8] = count_byte;
        end
        2'd2:    read_value_out[15:0] = divisor;
        default: read_value_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_uart_tx.sv
// Directed bench for rv32_uart_tx: register vector table plus serial-frame sequences.
// Build with UART_TX_PARITY_EN defined to exercise the parity framing.
`timescale 1ns/1ps
module tb_rv32_uart_tx;

  localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
  localparam logic [31:0] STAT_P     = 32'h0000_0010;
`else
  localparam int unsigned FRAME_BITS = 10;
  localparam logic [31:0] STAT_P     = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;
  logic        tx_out;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_bytes [32];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [15];

  rv32_uart_tx #(
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(16),
    .DEFAULT_DIVISOR(16'd104)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address_in(address_in),
    .write_mask_in(write_mask_in),
    .write_value_in(write_value_in),
    .read_value_out(read_value_out),
    .tx_out(tx_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    @(negedge clk);
    address_in     = addr;
    write_mask_in  = mask;
    write_value_in = data;
    @(posedge clk);
    #1;
    write_mask_in = '0;
    address_in    = '0;
  endtask

  task automatic check_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    address_in    = addr;
    write_mask_in = '0;
    #1;
    check(name, read_value_out, exp);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int unsigned i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Waits (bounded) for the start bit, then checks every cycle of n back-to-back frames.
  task automatic check_stream(input int unsigned div, input int unsigned n, input int unsigned exp_lat);
    int unsigned lat;
    int unsigned per;
    int unsigned bad;
    lat = 0;
    per = (div == 0) ? 1 : div;
    while (tx_out !== 1'b0 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("start_latency", lat, exp_lat);
    if (tx_out !== 1'b0) return;
    for (int unsigned f = 0; f < n; f++) begin
      bad = 0;
      for (int unsigned b = 0; b < FRAME_BITS; b++) begin
        for (int unsigned c = 0; c < per; c++) begin
          if (tx_out !== frame_bit(exp_bytes[f], b)) bad++;
          @(posedge clk);
          #1;
        end
      end
      check($sformatf("frame%0d_byte%02h_bad_cycles", f, exp_bytes[f]), bad, 0);
    end
  endtask

  initial begin
    int unsigned skip;

    vecs[0]  = '{BASE + 32'h4,  4'b0000, 32'h0,         32'h0000_0004 | STAT_P};
    vecs[1]  = '{BASE + 32'h8,  4'b0000, 32'h0,         32'd104};
    vecs[2]  = '{BASE + 32'h0,  4'b0000, 32'h0,         32'h0};
    vecs[3]  = '{BASE + 32'hC,  4'b0000, 32'h0,         32'h0};
    vecs[4]  = '{BASE + 32'h8,  4'b0001, 32'hAABB_CC12, 32'h0000_0012};
    vecs[5]  = '{BASE + 32'h8,  4'b0010, 32'h0000_3400, 32'h0000_3412};
    vecs[6]  = '{BASE + 32'h8,  4'b1100, 32'hFFFF_0000, 32'h0000_3412};
    vecs[7]  = '{BASE + 32'hC,  4'b1111, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{BASE + 32'h10, 4'b0001, 32'h0000_0041, 32'h0};
    vecs[9]  = '{BASE + 32'h4,  4'b0000, 32'h0,         32'h0000_0004 | STAT_P};
    vecs[10] = '{BASE + 32'h4,  4'b0001, 32'hFFFF_FFFF, 32'h0000_0004 | STAT_P};
    vecs[11] = '{BASE + 32'h8,  4'b0011, 32'h1234_0004, 32'h0000_0004};
    vecs[12] = '{32'h0002_0008, 4'b0000, 32'h0,         32'h0};
    vecs[13] = '{BASE + 32'h0,  4'b0010, 32'h0000_FF00, 32'h0};
    vecs[14] = '{BASE + 32'h4,  4'b0000, 32'h0,         32'h0000_0004 | STAT_P};

    reset          = 1'b1;
    address_in     = '0;
    write_mask_in  = '0;
    write_value_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("tx_during_reset", tx_out, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("tx_after_reset", tx_out, 1'b1);

    // Register map vectors; the last DIVISOR write leaves 4 cycles/bit
    for (int unsigned i = 0; i < 15; i++) begin
      if (vecs[i].mask != 4'b0000) bus_write(vecs[i].addr, vecs[i].mask, vecs[i].wdata);
      check_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Single frame, DIVISOR=4
    exp_bytes[0] = 8'hA5;
    bus_write(BASE, 4'b0001, 32'h0000_00A5);
    check("tx_idle_at_write_edge", tx_out, 1'b1);
    check_stream(4, 1, 1);
    check_read(BASE + 32'h4, 32'h0000_0004 | STAT_P, "status_after_frame");

    // Fill, overflow, clear, push-during-pop while full, gapless frames
    bus_write(BASE + 32'h8, 4'b0011, 32'h0000_0002);
    for (int unsigned i = 0; i < 17; i++) exp_bytes[i] = 8'h30 + 8'(i);
    exp_bytes[17] = 8'hC3;
    bus_write(BASE, 4'b0001, 32'h0000_0030);
    fork
      check_stream(2, 18, 1);
      begin
        for (int unsigned i = 1; i < 17; i++) bus_write(BASE, 4'b0001, 32'h30 + i);
        check_read(BASE + 32'h4, 32'h0000_1003 | STAT_P, "status_full");
        bus_write(BASE, 4'b0001, 32'h0000_00EE);
        check_read(BASE + 32'h4, 32'h0000_100B | STAT_P, "status_overflow");
        bus_write(BASE + 32'h4, 4'b0001, 32'h0000_0008);
        check_read(BASE + 32'h4, 32'h0000_1003 | STAT_P, "overflow_cleared");
        // First pop after the initial one lands FRAME_BITS*2 edges after it (edge index 1)
        skip = FRAME_BITS * 2 + 1 - 19;
        repeat (skip) @(posedge clk);
        bus_write(BASE, 4'b0001, 32'h0000_00C3);
        check_read(BASE + 32'h4, 32'h0000_1003 | STAT_P, "push_while_full_and_pop");
      end
    join
    check_read(BASE + 32'h4, 32'h0000_0004 | STAT_P, "status_after_burst");

    // Reset in the middle of data bit 3
    exp_bytes[0] = 8'h00;
    bus_write(BASE + 32'h8, 4'b0011, 32'h0000_0004);
    bus_write(BASE, 4'b0001, 32'h0000_0000);
    repeat (17) @(posedge clk);
    #1;
    check("tx_mid_bit3", tx_out, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("tx_on_reset_assert", tx_out, 1'b1);
    check_read(BASE + 32'h4, 32'h0000_0004 | STAT_P, "status_on_reset");
    check_read(BASE + 32'h8, 32'd104, "divisor_on_reset");
    @(negedge clk);
    reset = 1'b0;
    bus_write(BASE + 32'h8, 4'b0011, 32'h0000_0003);
    exp_bytes[0] = 8'h3C;
    bus_write(BASE, 4'b0001, 32'h0000_003C);
    check_stream(3, 1, 1);
    check_read(BASE + 32'h4, 32'h0000_0004 | STAT_P, "status_after_reset_frame");

    // DIVISOR=0 gives one-cycle bits
    bus_write(BASE + 32'h8, 4'b0011, 32'h0000_0000);
    check_read(BASE + 32'h8, 32'h0, "divisor_zero");
    exp_bytes[0] = 8'h5A;
    bus_write(BASE, 4'b0001, 32'h0000_005A);
    check_stream(0, 1, 1);
    check_read(BASE + 32'h4, 32'h0000_0004 | STAT_P, "status_after_div0");

`ifdef UART_TX_PARITY_EN
    bus_write(BASE + 32'h8, 4'b0011, 32'h0000_0001);
    exp_bytes[0] = 8'h07;
    bus_write(BASE, 4'b0001, 32'h0000_0007);
    check_stream(1, 1, 1);
    check_read(BASE + 32'h4, 32'h0000_0014, "status_parity_flag");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
